// File: rtl/rca_response_checker.sv
`default_nettype none
// ============================================================================
// Module      : rca_response_checker
// Description : Exhaustive response checker for a ripple-carry adder. Sweeps
//               every {cin, b, a} combination into the adder under test,
//               samples {cout, sum} after a programmable settle interval and
//               compares it with a + b + cin. Reports the error count, the
//               first failing vector and a pass flag.
// Revision    : 1.0 - initial release
// ============================================================================
module rca_response_checker #(
    parameter int WIDTH  = 4,
    parameter int SETTLE = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    output logic [WIDTH-1:0]     dut_a,
    output logic [WIDTH-1:0]     dut_b,
    output logic                 dut_cin,
    input  logic [WIDTH-1:0]     dut_sum,
    input  logic                 dut_cout,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic [2*WIDTH+1:0]   err_count,
    output logic                 first_fail_valid,
    output logic [2*WIDTH:0]     first_fail_vec
);

    // Vector is {cin, b, a}; the error counter is one bit wider so it can
    // hold the full vector count without wrapping.
    localparam int c_VW    = 2*WIDTH + 1;
    localparam int c_EW    = 2*WIDTH + 2;
    localparam int c_CNT_W = $clog2(SETTLE + 1);

    localparam logic [c_VW-1:0]    c_VEC_ONE     = {{(c_VW-1){1'b0}}, 1'b1};
    localparam logic [c_EW-1:0]    c_ERR_ONE     = {{(c_EW-1){1'b0}}, 1'b1};
    localparam logic [c_CNT_W-1:0] c_CNT_ONE     = {{(c_CNT_W-1){1'b0}}, 1'b1};
    localparam logic [c_CNT_W-1:0] c_SETTLE_LAST = c_CNT_W'(SETTLE - 1);

    localparam logic [2:0] c_S_IDLE  = 3'd0;
    localparam logic [2:0] c_S_APPLY = 3'd1;
    localparam logic [2:0] c_S_WAIT  = 3'd2;
    localparam logic [2:0] c_S_CHECK = 3'd3;
    localparam logic [2:0] c_S_DONE  = 3'd4;

    logic [2:0]         r_state;
    logic [2:0]         w_state_nxt;
    logic [c_VW-1:0]    r_vec;
    logic [c_VW-1:0]    r_ops;
    logic [c_CNT_W-1:0] r_cnt;
    logic [c_EW-1:0]    r_err;
    logic               r_ffv;
    logic [c_VW-1:0]    r_ffvec;

    logic [WIDTH:0]     w_golden;
    logic               w_mismatch;
    logic               w_vec_last;
    logic               w_settle_end;

    // Golden result is formed from the operands actually driven, at full
    // WIDTH+1 precision so the carry-out is checked as well.
    assign w_golden     = {1'b0, dut_a} + {1'b0, dut_b} + {{WIDTH{1'b0}}, dut_cin};
    assign w_mismatch   = ({dut_cout, dut_sum} != w_golden);
    assign w_vec_last   = &r_vec;
    assign w_settle_end = (r_cnt == c_SETTLE_LAST);

    assign {dut_cin, dut_b, dut_a} = r_ops;
    assign err_count        = r_err;
    assign first_fail_valid = r_ffv;
    assign first_fail_vec   = r_ffvec;

    assign busy = (r_state == c_S_APPLY) || (r_state == c_S_WAIT) || (r_state == c_S_CHECK);
    assign done = (r_state == c_S_DONE);
    assign pass = done && (r_err == '0);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode: one APPLY, SETTLE WAITs and one CHECK per vector.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_S_IDLE:  if (start) w_state_nxt = c_S_APPLY;
            c_S_APPLY: w_state_nxt = c_S_WAIT;
            c_S_WAIT:  if (w_settle_end) w_state_nxt = c_S_CHECK;
            c_S_CHECK: w_state_nxt = w_vec_last ? c_S_DONE : c_S_APPLY;
            c_S_DONE:  if (start) w_state_nxt = c_S_APPLY;
            default:   w_state_nxt = c_S_IDLE;
        endcase
    end

    // Datapath: vector counter, operand register, settle timer and results.
    // Operands are loaded on the edge that enters APPLY, so the value seen by
    // the adder always matches the vector being checked.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_vec   <= '0;
            r_ops   <= '0;
            r_cnt   <= '0;
            r_err   <= '0;
            r_ffv   <= 1'b0;
            r_ffvec <= '0;
        end else begin
            case (r_state)
                c_S_IDLE, c_S_DONE: begin
                    if (start) begin
                        r_vec   <= '0;
                        r_ops   <= '0;
                        r_err   <= '0;
                        r_ffv   <= 1'b0;
                        r_ffvec <= '0;
                    end
                end
                c_S_APPLY: begin
                    r_cnt <= '0;
                end
                c_S_WAIT: begin
                    r_cnt <= r_cnt + c_CNT_ONE;
                end
                c_S_CHECK: begin
                    if (w_mismatch) begin
                        r_err <= r_err + c_ERR_ONE;
                        if (!r_ffv) begin
                            r_ffv   <= 1'b1;
                            r_ffvec <= r_vec;
                        end
                    end
                    // On the last vector the operands are left holding it.
                    if (!w_vec_last) begin
                        r_vec <= r_vec + c_VEC_ONE;
                        r_ops <= r_vec + c_VEC_ONE;
                    end
                end
                default: begin
                    r_cnt <= '0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
